// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter between instruction fetch and the load/store buffer.
// Define MEM_CTRL_RR_EN for round-robin arbitration; the default build uses fixed LSB priority.
module mem_ctrl #(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [1:0]  IO_PREFIX  = 2'b11
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  if_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic [31:0]           if_data,
   input  logic                  lsb_valid,
   input  logic                  lsb_wr,
   input  logic [2:0]            lsb_size,
   input  logic [ADDR_WIDTH-1:0] lsb_addr,
   input  logic [31:0]           lsb_value,
   output logic                  lsb_ready,
   output logic [31:0]           lsb_res,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d, n_q, n_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  sext_q, sext_d, id_q, id_d;
   logic [31:0]           value_q, value_d, buf_q, buf_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  mem_wr_q, mem_wr_d;
   logic                  if_ready_q, if_ready_d, lsb_ready_q, lsb_ready_d;
   logic [31:0]           if_data_q, if_data_d, lsb_res_q, lsb_res_d;

   logic                  grant, grant_lsb, req_stall, io_stall;
   logic [2:0]            req_n;
   logic [1:0]            byte_idx;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic [31:0]           word_c, ext_c;

`ifdef MEM_CTRL_RR_EN
   logic last_grant_q, last_grant_d;  // 1 = LSB was granted last

   assign grant_lsb    = lsb_valid && (!if_valid || !last_grant_q);
   assign last_grant_d = grant ? grant_lsb : last_grant_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   last_grant_q <= 1'b0;
      else if (rdy_in) last_grant_q <= last_grant_d;
   end
`else
   assign grant_lsb = lsb_valid;
`endif

   assign grant     = (state_q == S_IDLE) && !flush_in && (lsb_valid || if_valid);
   assign req_n     = (lsb_size[1:0] == 2'd0) ? 3'd1 : (lsb_size[1:0] == 2'd1) ? 3'd2 : 3'd4;
   assign req_stall = (lsb_addr[17:16] == IO_PREFIX) && io_buffer_full;
   assign io_stall  = (addr_q[17:16] == IO_PREFIX) && io_buffer_full;
   assign beat_addr = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
   assign byte_idx  = cnt_q[1:0] - 2'd1;

   // Current byte merged in so the final beat's data reaches the result in the same cycle.
   always_comb begin
      word_c = buf_q;
      word_c[{byte_idx, 3'b000} +: 8] = mem_din;
      case (n_q)
         3'd1:    ext_c = {{24{sext_q & word_c[7]}}, word_c[7:0]};
         3'd2:    ext_c = {{16{sext_q & word_c[15]}}, word_c[15:0]};
         default: ext_c = word_c;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         addr_q      <= '0;
         sext_q      <= 1'b0;
         id_q        <= 1'b0;
         value_q     <= '0;
         buf_q       <= '0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         if_ready_q  <= 1'b0;
         if_data_q   <= '0;
         lsb_ready_q <= 1'b0;
         lsb_res_q   <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         addr_q      <= addr_d;
         sext_q      <= sext_d;
         id_q        <= id_d;
         value_q     <= value_d;
         buf_q       <= buf_d;
         mem_a_q     <= mem_a_d;
         mem_dout_q  <= mem_dout_d;
         mem_wr_q    <= mem_wr_d;
         if_ready_q  <= if_ready_d;
         if_data_q   <= if_data_d;
         lsb_ready_q <= lsb_ready_d;
         lsb_res_q   <= lsb_res_d;
      end else begin
         mem_wr_q <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      addr_d  = addr_q;
      sext_d  = sext_q;
      id_d    = id_q;
      value_d = value_q;
      case (state_q)
         S_IDLE: if (grant) begin
            id_d    = grant_lsb;
            addr_d  = grant_lsb ? lsb_addr : if_addr;
            n_d     = grant_lsb ? req_n : 3'd4;
            sext_d  = grant_lsb && !lsb_size[2];
            value_d = lsb_value;
            if (grant_lsb && lsb_wr) begin
               state_d = S_WRITE;
               cnt_d   = req_stall ? 3'd0 : 3'd1;
            end else begin
               state_d = S_READ;
               cnt_d   = 3'd1;
            end
         end
         S_READ: begin
            if (flush_in) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q < n_q) begin
               cnt_d = cnt_q + 3'd1;
            end else begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_WRITE: begin
            if (cnt_q < n_q) begin
               if (!io_stall) cnt_d = cnt_q + 3'd1;
            end else begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_a_d     = mem_a_q;
      mem_dout_d  = mem_dout_q;
      mem_wr_d    = 1'b0;
      if_ready_d  = 1'b0;
      lsb_ready_d = 1'b0;
      if_data_d   = if_data_q;
      lsb_res_d   = lsb_res_q;
      buf_d       = buf_q;
      case (state_q)
         S_IDLE: if (grant) begin
            buf_d   = '0;
            mem_a_d = grant_lsb ? lsb_addr : if_addr;
            if (grant_lsb && lsb_wr && !req_stall) begin
               mem_wr_d   = 1'b1;
               mem_dout_d = lsb_value[7:0];
            end
         end
         S_READ: if (!flush_in) begin
            buf_d = word_c;
            if (cnt_q < n_q) begin
               mem_a_d = beat_addr;
            end else if (id_q) begin
               lsb_ready_d = 1'b1;
               lsb_res_d   = ext_c;
            end else begin
               if_ready_d = 1'b1;
               if_data_d  = word_c;
            end
         end
         S_WRITE: begin
            if (cnt_q < n_q) begin
               if (!io_stall) begin
                  mem_a_d    = beat_addr;
                  mem_dout_d = value_q[{cnt_q[1:0], 3'b000} +: 8];
                  mem_wr_d   = 1'b1;
               end
            end else begin
               lsb_ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   assign mem_wr    = mem_wr_q;
   assign if_ready  = if_ready_q;
   assign if_data   = if_data_q;
   assign lsb_ready = lsb_ready_q;
   assign lsb_res   = lsb_res_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reads, extension, stores, arbitration, IO stall, flush, reset, pause.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        flush_in = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready;
   logic [31:0] if_data;
   logic        lsb_valid = 1'b0;
   logic        lsb_wr = 1'b0;
   logic [2:0]  lsb_size = '0;
   logic [31:0] lsb_addr = '0;
   logic [31:0] lsb_value = '0;
   logic        lsb_ready;
   logic [31:0] lsb_res;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full = 1'b0;

   logic [7:0]  ram [0:65535];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk_in = ~clk_in;

   // Read data tracks the registered address, i.e. one cycle after the controller chose it.
   assign mem_din = ram[mem_a[15:0]];

   mem_ctrl #(.ADDR_WIDTH(32), .IO_PREFIX(2'b11)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
      .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
      .lsb_value(lsb_value), .lsb_ready(lsb_ready), .lsb_res(lsb_res),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic do_load(input logic is_if, input logic [31:0] addr, input logic [2:0] size,
                          input int n, input logic [31:0] exp, input string tag);
      step();
      if (is_if) begin
         if_valid = 1'b1; if_addr = addr;
      end else begin
         lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = size; lsb_addr = addr;
      end
      for (int k = 0; k < n; k++) begin
         step();
         check({tag, "_addr"}, mem_a, addr + 32'(k));
         check({tag, "_early"}, 32'(is_if ? if_ready : lsb_ready), 32'd0);
      end
      step();
      check({tag, "_ready"}, 32'(is_if ? if_ready : lsb_ready), 32'd1);
      check({tag, "_data"}, is_if ? if_data : lsb_res, exp);
      $display("[%0t] %s load @%08h size %0d -> %08h", $time, tag, addr, size, is_if ? if_data : lsb_res);
      if_valid = 1'b0; lsb_valid = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [2:0] size, input int n,
                           input logic [31:0] value, input int stall, input string tag);
      logic [31:0] v;
      step();
      lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = size; lsb_addr = addr; lsb_value = value;
      io_buffer_full = (stall > 0);
      for (int s = 0; s < stall; s++) begin
         step();
         check({tag, "_stall_wr"}, 32'(mem_wr), 32'd0);
         if (s == stall - 1) io_buffer_full = 1'b0;
      end
      for (int k = 0; k < n; k++) begin
         step();
         v = value >> (8 * k);
         check({tag, "_wr"}, 32'(mem_wr), 32'd1);
         check({tag, "_addr"}, mem_a, addr + 32'(k));
         check({tag, "_dout"}, 32'(mem_dout), {24'b0, v[7:0]});
      end
      step();
      check({tag, "_wr_end"}, 32'(mem_wr), 32'd0);
      check({tag, "_ready"}, 32'(lsb_ready), 32'd1);
      $display("[%0t] %s store @%08h value %08h stall %0d", $time, tag, addr, value, stall);
      lsb_valid = 1'b0; lsb_wr = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
      ram[16'h0020] = 8'h80; ram[16'h0021] = 8'hF0;
      ram[16'h2000] = 8'h01; ram[16'h2001] = 8'h02; ram[16'h2002] = 8'h03; ram[16'h2003] = 8'h04;
      ram[16'h3000] = 8'h7F;

      // reset state
      step();
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_lsb_ready", 32'(lsb_ready), 32'd0);
      check("rst_lsb_res", lsb_res, 32'd0);
      rst_n_in = 1'b1;

      // IF word fetch, then pulse is one cycle and data holds
      do_load(1'b1, 32'h0000_1000, 3'b010, 4, 32'h0010_0513, "if_fetch");
      step();
      check("if_pulse_len", 32'(if_ready), 32'd0);
      check("if_data_hold", if_data, 32'h0010_0513);

      // sign/zero extension
      do_load(1'b0, 32'h20, 3'b000, 1, 32'hFFFF_FF80, "lb");
      do_load(1'b0, 32'h20, 3'b100, 1, 32'h0000_0080, "lbu");
      do_load(1'b0, 32'h20, 3'b001, 2, 32'hFFFF_F080, "lh");
      do_load(1'b0, 32'h20, 3'b101, 2, 32'h0000_F080, "lhu");
      do_load(1'b0, 32'h1000, 3'b010, 4, 32'h0010_0513, "lw");

      do_store(32'h100, 3'b010, 4, 32'hDEAD_BEEF, 0, "sw");
      do_store(32'h0003_0000, 3'b000, 1, 32'h0000_0055, 3, "sb_io");

      // simultaneous requests, LSB was granted last
      step();
      if_valid = 1'b1; if_addr = 32'h2000;
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = 3'b100; lsb_addr = 32'h3000;
`ifdef MEM_CTRL_RR_EN
      step(); check("arb_first", mem_a, 32'h2000);
      for (int k = 1; k < 4; k++) begin step(); check("arb_if_addr", mem_a, 32'h2000 + 32'(k)); end
      step(); check("arb_if_ready", 32'(if_ready), 32'd1); check("arb_if_data", if_data, 32'h0403_0201);
      if_valid = 1'b0;
      step(); check("arb_done_nogrant", mem_a, 32'h2003);
      step(); check("arb_second", mem_a, 32'h3000);
      step(); check("arb_lsb_ready", 32'(lsb_ready), 32'd1); check("arb_lsb_res", lsb_res, 32'h7F);
      lsb_valid = 1'b0;
`else
      step(); check("arb_first", mem_a, 32'h3000);
      step(); check("arb_lsb_ready", 32'(lsb_ready), 32'd1); check("arb_lsb_res", lsb_res, 32'h7F);
      lsb_valid = 1'b0;
      step(); check("arb_done_nogrant", mem_a, 32'h3000);
      step(); check("arb_second", mem_a, 32'h2000);
      for (int k = 1; k < 4; k++) begin step(); check("arb_if_addr", mem_a, 32'h2000 + 32'(k)); end
      step(); check("arb_if_ready", 32'(if_ready), 32'd1); check("arb_if_data", if_data, 32'h0403_0201);
      if_valid = 1'b0;
`endif
      $display("[%0t] arbitration pair done: if %08h lsb %08h", $time, if_data, lsb_res);

      // reset in the middle of a store
      step();
      lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = 3'b010; lsb_addr = 32'h100; lsb_value = 32'h1122_3344;
      step(); check("rstsw_wr", 32'(mem_wr), 32'd1);
      step(); check("rstsw_addr", mem_a, 32'h101);
      #2 rst_n_in = 1'b0; lsb_valid = 1'b0; lsb_wr = 1'b0;
      #1;
      check("rstsw_mem_wr", 32'(mem_wr), 32'd0);
      check("rstsw_mem_a", mem_a, 32'd0);
      check("rstsw_dout", 32'(mem_dout), 32'd0);
      check("rstsw_if_data", if_data, 32'd0);
      check("rstsw_lsb_res", lsb_res, 32'd0);
      step(); rst_n_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rstsw_no_beat", 32'(mem_wr), 32'd0);
         check("rstsw_no_ready", 32'(lsb_ready), 32'd0);
      end
      $display("[%0t] store abandoned by reset", $time);

      // pause holds the request off
      rdy_in = 1'b0;
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = 3'b000; lsb_addr = 32'h20;
      step(); check("pause_hold1", mem_a, 32'd0);
      step(); check("pause_hold2", mem_a, 32'd0);
      rdy_in = 1'b1;
      step(); check("pause_grant", mem_a, 32'h20);
      step(); check("pause_ready", 32'(lsb_ready), 32'd1); check("pause_res", lsb_res, 32'hFFFF_FF80);
      lsb_valid = 1'b0;
      $display("[%0t] paused load -> %08h", $time, lsb_res);

      // flush in IDLE blocks the grant for one cycle
      step();
      lsb_valid = 1'b1; lsb_size = 3'b000; lsb_addr = 32'h21; flush_in = 1'b1;
      step(); check("flush_idle_block", mem_a, 32'h20);
      flush_in = 1'b0;
      step(); check("flush_idle_grant", mem_a, 32'h21);
      step(); check("flush_idle_ready", 32'(lsb_ready), 32'd1); check("flush_idle_res", lsb_res, 32'hFFFF_FFF0);
      lsb_valid = 1'b0;
      $display("[%0t] flush-in-idle load -> %08h", $time, lsb_res);

      // flush aborts an IF read
      step();
      if_valid = 1'b1; if_addr = 32'h1000;
      step(); check("flush_rd_addr", mem_a, 32'h1000);
      flush_in = 1'b1; if_valid = 1'b0;
      step(); flush_in = 1'b0;
      check("flush_rd_stop", mem_a, 32'h1000);
      check("flush_rd_noready", 32'(if_ready), 32'd0);
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = 3'b000; lsb_addr = 32'h20;
      step(); check("flush_rd_idle", mem_a, 32'h20); check("flush_rd_noready2", 32'(if_ready), 32'd0);
      step(); check("flush_rd_lsb", lsb_res, 32'hFFFF_FF80); check("flush_rd_noready3", 32'(if_ready), 32'd0);
      lsb_valid = 1'b0;
      $display("[%0t] IF read aborted by flush, follow-up load -> %08h", $time, lsb_res);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
